disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl.sv | 111 +++++++++++
 tb/tb_disp_scan_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - multiplexed 4-digit display scanner with frame-synchronous shadow load
// Every output is a flop fed from next-state values, so outputs line up with the current FSM state.

module disp_scan_ctrl #(
  parameter int DIV = 1000,
  parameter int GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  digit_data,
  output logic [3:0]  digit_sel_n,
  output logic        load_ack,
  output logic        pending
);

  localparam int CMAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  typedef enum logic {ST_SHOW, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          ack_q, ack_d;
  logic [3:0]    data_q, data_d;
  logic [3:0]    sel_q, sel_d;
  logic          boundary;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    boundary  = 1'b0;

    if (state_q == ST_SHOW) begin
      if (cnt_q == DIV_LAST) begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == GAP_LAST) begin
        state_d  = ST_SHOW;
        cnt_d    = '0;
        idx_d    = idx_q + 2'd1;
        boundary = (idx_q == 2'd3);
      end
    end

    // Apply the old shadow first so a load on the boundary cycle stays pending for the next frame.
    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end
    if (load) begin
      shadow_d  = din;
      pending_d = 1'b1;
    end

    sel_d  = 4'b1111;
    data_d = data_q;
    if (state_d == ST_SHOW) begin
      data_d = disp_d[{idx_d, 2'b00} +: 4];
      if (!blank_mask[idx_d]) begin
        sel_d[idx_d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_GAP;
      cnt_q     <= '0;
      idx_q     <= 2'd3;
      disp_q    <= 16'h0000;
      shadow_q  <= 16'h0000;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      data_q    <= 4'h0;
      sel_q     <= 4'b1111;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
    end
  end

  assign digit_data  = data_q;
  assign digit_sel_n = sel_q;
  assign load_ack    = ack_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl against a timeline model
// The model indexes time by cycles since reset release: 2 gap cycles, then 6-cycle digit slots.

module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  digit_data;
  logic [3:0]  digit_sel_n;
  logic        load_ack;
  logic        pending;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIV(4), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din), .blank_mask(blank_mask),
    .digit_data(digit_data), .digit_sel_n(digit_sel_n), .load_ack(load_ack), .pending(pending)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  int          mt;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend, m_ack, m_bnd;
  logic [3:0]  m_mask, m_last, es;

  function automatic bit is_show(int t);
    return (t >= 2) && (((t - 2) % 6) < 4);
  endfunction

  function automatic int dig(int t);
    return (t < 2) ? 3 : (((t - 2) / 6) % 4);
  endfunction

  task automatic model_reset();
    mt = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0; m_ack = 1'b0;
    m_last = 4'h0; m_mask = 4'h0;
  endtask

  task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", nm, act, exp, mt);
    end
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  // A frame boundary is the edge into the first show cycle of digit 0 (t = 2 + 24k).
  always @(posedge clk) begin
    if (rst_n) begin
      m_bnd = ((mt + 1) >= 2) && (((mt + 1 - 2) % 24) == 0);
      m_ack = m_bnd && m_pend;
      if (m_ack) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (load) begin
        m_shadow = din;
        m_pend   = 1'b1;
      end
      m_mask = blank_mask;
      mt++;
    end
  end

  always @(negedge clk) begin
    es = 4'hf;
    if (is_show(mt)) begin
      m_last = m_disp[dig(mt)*4 +: 4];
      if (!m_mask[dig(mt)]) es[dig(mt)] = 1'b0;
    end
    cmp("model_sel", digit_sel_n, es);
    cmp("model_data", digit_data, m_last);
    cmp("model_ack", load_ack, m_ack);
    cmp("model_pending", pending, m_pend);
  end

  task automatic wait_to(int n);
    int g = 0;
    while (mt < n && g < 3000) begin
      @(negedge clk);
      ack_cnt += load_ack;
      g++;
    end
    if (mt != n) cmp("wait_to", 16'(mt), 16'(n));
  endtask

  logic [3:0] exp_sel [0:8];
  int tgt;

  initial begin
    exp_sel = '{4'hf, 4'hf, 4'he, 4'he, 4'he, 4'he, 4'hf, 4'hf, 4'hd};

    repeat (3) @(negedge clk);
    cmp("rst_sel", digit_sel_n, 4'hf);
    cmp("rst_data", digit_data, 4'h0);
    rst_n = 1'b1;
    #1 cmp("lit_sel_0", digit_sel_n, exp_sel[0]);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      cmp("lit_sel", digit_sel_n, exp_sel[i]);
      if (i >= 2 && i <= 5) cmp("lit_data0", digit_data, 4'h0);
    end

    wait_to(8);  load = 1'b1; din = 16'h4321;
    wait_to(9);  load = 1'b0;
    cmp("pend_set", pending, 1'b1);
    wait_to(25); cmp("pend_hold", pending, 1'b1);
    wait_to(26); cmp("ack_4321", load_ack, 1'b1); cmp("pend_clr", pending, 1'b0);
    cmp("d0_4321", digit_data, 4'h1);
    wait_to(27); cmp("ack_pulse_end", load_ack, 1'b0);
    wait_to(32); cmp("d1_4321", digit_data, 4'h2);
    wait_to(38); cmp("d2_4321", digit_data, 4'h3);
    wait_to(44); cmp("d3_4321", digit_data, 4'h4);

    wait_to(50); load = 1'b1; din = 16'hAAAA;
    wait_to(51); load = 1'b0;
    wait_to(52); load = 1'b1; din = 16'h5678;
    wait_to(53); load = 1'b0; ack_cnt = 0;
    wait_to(74); cmp("ack_5678", load_ack, 1'b1); cmp("d0_5678", digit_data, 4'h8);
    wait_to(80); cmp("d1_5678", digit_data, 4'h7);
    wait_to(86); cmp("d2_5678", digit_data, 4'h6);
    wait_to(92); cmp("d3_5678", digit_data, 4'h5);
    wait_to(98); cmp("single_ack", 16'(ack_cnt), 16'd1);

    wait_to(100); load = 1'b1; din = 16'h1234;
    wait_to(101); load = 1'b0;
    wait_to(121); load = 1'b1; din = 16'hBEEF;
    wait_to(122); load = 1'b0;
    cmp("ack_1234", load_ack, 1'b1); cmp("pend_keep", pending, 1'b1);
    cmp("d0_1234", digit_data, 4'h4);
    wait_to(146); cmp("ack_beef", load_ack, 1'b1); cmp("pend_beef", pending, 1'b0);
    cmp("d0_beef", digit_data, 4'hF);

    wait_to(150); blank_mask = 4'b0100;
    wait_to(176); cmp("mask_d1", digit_sel_n, 4'b1101);
    for (int n = 182; n <= 185; n++) begin
      wait_to(n); cmp("mask_d2", digit_sel_n, 4'b1111);
    end
    wait_to(188); cmp("mask_d3", digit_sel_n, 4'b0111);
    wait_to(194); cmp("mask_d0", digit_sel_n, 4'b1110);
    blank_mask = 4'h0;

    repeat (800) begin
      @(negedge clk);
      load = ($urandom % 8) == 0;
      din  = 16'($urandom);
      if (($urandom % 16) == 0) blank_mask = 4'($urandom);
    end
    @(negedge clk); load = 1'b0; blank_mask = 4'h0;

    tgt = mt + 2;
    while (!(is_show(tgt) && dig(tgt) == 2 && is_show(tgt - 1) && dig(tgt - 1) == 2)) tgt++;
    wait_to(tgt - 1); load = 1'b1; din = 16'h9999;
    wait_to(tgt);     load = 1'b0;
    cmp("pend_pre_rst", pending, 1'b1);
    cmp("sel_pre_rst", digit_sel_n, 4'b1011);
    #2 rst_n = 1'b0;
    #1 cmp("rst_sel_now", digit_sel_n, 4'hf);
    cmp("rst_pend_now", pending, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_cnt = 0;
    wait_to(2);  cmp("post_rst_data", digit_data, 4'h0); cmp("post_rst_pend", pending, 1'b0);
    wait_to(30); cmp("post_rst_acks", 16'(ack_cnt), 16'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
